// File: rtl/alu_issue_unit_if.sv
// Instruction channel into alu_issue_unit: valid/ready handshake carrying opcode and register fields.
// The master offers the instruction and the slave returns ready.
interface alu_issue_unit_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_rd,
    output instr_rs,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_rd,
    input  instr_rs,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue front-end for an external combinational 8-bit ALU: owns the register file and sequences read, execute and writeback.
// MULTIPLY writes its high byte a cycle later. Optional overflow trap is enabled by defining ALU_OVF_TRAP_EN.
module alu_issue_unit #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_unit_if.slave      instr,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [7:0]           ld_data,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [3:0]           alu_fsl,
  input  logic [7:0]           alu_result,
  input  logic [7:0]           alu_mul_high,
  input  logic [3:0]           alu_sreg,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic                 wb_valid,
  output logic [AW-1:0]        wb_addr,
  output logic [7:0]           wb_data,
`ifdef ALU_OVF_TRAP_EN
  output logic                 ovf_trap,
  input  logic                 trap_clr,
`endif
  input  logic [AW-1:0]        rd_addr,
  output logic [7:0]           rd_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB_HI} state_t;

  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  state_t        state, state_nxt;
  logic [7:0]    regs [NREGS];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_hi;
  logic [3:0]    op_q;
  logic [7:0]    hold;
  logic          ready_int;
  logic          accept;
  logic          exec_wr;
  logic          hi_wr;
  logic          trap_hit;
  logic          trap_block;

  assign rd_hi = rd_q + AW'(1);

`ifdef ALU_OVF_TRAP_EN
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBC = 4'h3;

  // Signed overflow on an add/subtract blocks the writeback and parks the unit until cleared.
  assign trap_hit   = (state == EXEC) && alu_sreg[3] &&
                      (op_q inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC});
  assign trap_block = ovf_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_trap <= 1'b0;
    end else if (trap_clr && (state == IDLE)) begin
      ovf_trap <= 1'b0;
    end else if (trap_hit) begin
      ovf_trap <= 1'b1;
    end
  end
`else
  assign trap_hit   = 1'b0;
  assign trap_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = (op_q == OP_MUL) ? WB_HI : IDLE;
      WB_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_int = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    exec_wr   = 1'b0;
    hi_wr     = 1'b0;
    case (state)
      IDLE: begin
        ready_int = !ld_en && !trap_block;
        accept    = ready_int && instr.instr_valid;
      end
      EXEC: begin
        busy    = 1'b1;
        exec_wr = (op_q != OP_CMP) && !trap_hit;
      end
      WB_HI: begin
        busy  = 1'b1;
        hi_wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr.instr_ready = ready_int;

  // Load, low-byte and high-byte writes are exclusive by state, so one write port suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if ((state == IDLE) && ld_en) begin
      regs[ld_addr] <= ld_data;
    end else if (exec_wr) begin
      regs[rd_q] <= alu_result;
    end else if (hi_wr) begin
      regs[rd_hi] <= hold;
    end
  end

  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A    <= '0;
      alu_B    <= '0;
      alu_fsl  <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      hold     <= '0;
      flags    <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= exec_wr || hi_wr;
      if (accept) begin
        alu_A   <= regs[instr.instr_rd];
        alu_B   <= regs[instr.instr_rs];
        alu_fsl <= instr.instr_op;
        rd_q    <= instr.instr_rd;
        op_q    <= instr.instr_op;
      end
      if (state == EXEC) begin
        flags <= alu_sreg;
        if (op_q == OP_MUL) hold <= alu_mul_high;
      end
      if (exec_wr) begin
        wb_addr <= rd_q;
        wb_data <= alu_result;
      end else if (hi_wr) begin
        wb_addr <= rd_hi;
        wb_data <= hold;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: plays the ALU, keeps a timeline model of registers/flags/writebacks,
// compares every cycle and pins the model with hand-computed directed expectations.
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_unit_if ifc();
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] alu_A, alu_B, alu_result, alu_mul_high, wb_data, rd_data;
  logic [3:0] alu_fsl, alu_sreg, flags;
  logic       busy, wb_valid;
  logic [2:0] wb_addr;
  logic [2:0] rd_addr = '0;
`ifdef ALU_OVF_TRAP_EN
  logic ovf_trap;
  logic trap_clr = 1'b0;
`endif

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(ifc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_fsl(alu_fsl),
    .alu_result(alu_result), .alu_mul_high(alu_mul_high), .alu_sreg(alu_sreg),
    .flags(flags), .busy(busy), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef ALU_OVF_TRAP_EN
    .ovf_trap(ovf_trap), .trap_clr(trap_clr),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct packed {logic [7:0] res; logic [7:0] hi; logic [3:0] fl;} alu_out_t;

  // Reference ALU, flags {V,S,C,Z}; S is the result sign bit.
  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_out_t   o;
    logic [8:0] s;
    logic [15:0] p;
    o = '0;
    s = '0;
    p = '0;
    case (op)
      4'h0: begin
        s = {1'b0, a} + {1'b0, b};
        o.res = s[7:0];
        o.fl = {(a[7] == b[7]) && (s[7] != a[7]), s[7], s[8], s[7:0] == 8'd0};
      end
      4'hE: begin
        p = {8'd0, a} * {8'd0, b};
        o.res = p[7:0];
        o.hi = p[15:8];
        o.fl = {1'b0, p[15], p[15], p == 16'd0};
      end
      4'hF: begin
        s = {1'b0, a} - {1'b0, b};
        o.res = s[7:0];
        o.fl = {(a[7] != b[7]) && (s[7] != a[7]), s[7], s[8], s[7:0] == 8'd0};
      end
      default: begin
        o.res = a ^ b;
        o.fl = {3'b000, (a ^ b) == 8'd0};
      end
    endcase
    return o;
  endfunction

  alu_out_t ao;
  assign ao = alu_fn(alu_fsl, alu_A, alu_B);
  assign alu_result = ao.res;
  assign alu_mul_high = ao.hi;
  assign alu_sreg = ao.fl;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted instruction schedules its register/flag updates at future edges.
  typedef struct {int cyc; bit hi; bit wr; logic [2:0] addr; logic [7:0] data; logic [3:0] fl;} ev_t;
  ev_t        q[$];
  ev_t        ev;
  alu_out_t   mo;
  logic [7:0] mreg [8];
  logic [3:0] mflags;
  bit         exp_wb;
  logic [2:0] exp_wa;
  logic [7:0] exp_wd;
  bit         midle;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         acc_cyc[$];
  int         ld_cyc = 0;
  bit         cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      mflags = 4'h0;
      exp_wb = 1'b0;
    end else begin
      cyc++;
      midle = (q.size() == 0);
      exp_wb = 1'b0;
      while (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        if (!ev.hi) mflags = ev.fl;
        if (ev.wr) begin
          mreg[ev.addr] = ev.data;
          exp_wb = 1'b1;
          exp_wa = ev.addr;
          exp_wd = ev.data;
        end
      end
      if (midle && ld_en) begin
        mreg[ld_addr] = ld_data;
        ld_cyc = cyc;
      end else if (midle && ifc.instr_valid) begin
        mo = alu_fn(ifc.instr_op, mreg[ifc.instr_rd], mreg[ifc.instr_rs]);
        q.push_back('{cyc + 1, 1'b0, ifc.instr_op != 4'hF, ifc.instr_rd, mo.res, mo.fl});
        if (ifc.instr_op == 4'hE)
          q.push_back('{cyc + 2, 1'b1, 1'b1, ifc.instr_rd + 3'd1, mo.hi, 4'h0});
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("ready", ifc.instr_ready, (q.size() == 0) && !ld_en);
      chk("busy", busy, q.size() != 0);
      chk("flags", flags, mflags);
      chk("wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        chk("wb_addr", wb_addr, exp_wa);
        chk("wb_data", wb_data, exp_wd);
      end
      chk("rd_data", rd_data, mreg[rd_addr]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick(1);
    ld_en = 1'b0;
  endtask

  // Offer an instruction and return two time units after the edge that accepted it.
  task automatic offer(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input bit keep);
    int c0;
    c0 = acc_cnt;
    ifc.instr_op = op;
    ifc.instr_rd = rd;
    ifc.instr_rs = rs;
    ifc.instr_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == c0; i++) tick(1);
    if (acc_cnt == c0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=none want=accept op=%0h", op);
    end
    if (!keep) ifc.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    ifc.instr_valid = 1'b0;
    ifc.instr_op = '0;
    ifc.instr_rd = '0;
    ifc.instr_rs = '0;
    tick(2);
    chk("rst_flags", flags, 4'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_fsl", alu_fsl, 4'h0);
    chk("rst_ready", ifc.instr_ready, 1'b1);
    peek("rst_r5", 3'd5, 8'h00);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(1);

    // ADD 5 + 3
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    offer(4'h0, 3'd1, 3'd2, 1'b0);
    chk("add_busy_exec", busy, 1'b1);
    tick(1);
    peek("add_r1", 3'd1, 8'h08);
    chk("add_flags", flags, 4'h0);
    chk("add_wb_valid", wb_valid, 1'b1);
    chk("add_wb_addr", wb_addr, 3'd1);
    chk("add_wb_data", wb_data, 8'h08);
    chk("add_ready_back", ifc.instr_ready, 1'b1);

    // signed overflow
    load(3'd1, 8'h7F);
    load(3'd2, 8'h01);
    offer(4'h0, 3'd1, 3'd2, 1'b0);
    tick(1);
    peek("ovf_r1", 3'd1, 8'h80);
    chk("ovf_flags", flags, 4'hC);

    // MULTIPLY 0x10 * 0x20 = 0x0200
    load(3'd3, 8'h10);
    load(3'd4, 8'h20);
    offer(4'hE, 3'd3, 3'd4, 1'b0);
    tick(1);
    peek("mul_r3", 3'd3, 8'h00);
    chk("mul_ready_wbhi", ifc.instr_ready, 1'b0);
    chk("mul_busy_wbhi", busy, 1'b1);
    tick(1);
    peek("mul_r4", 3'd4, 8'h02);
    chk("mul_wb_addr_hi", wb_addr, 3'd4);
    chk("mul_flags", flags, 4'h0);
    chk("mul_ready_back", ifc.instr_ready, 1'b1);

    // MULTIPLY with rd=7 wraps the high byte into R0
    load(3'd7, 8'h40);
    load(3'd0, 8'h08);
    offer(4'hE, 3'd7, 3'd0, 1'b0);
    tick(2);
    peek("wrap_r7", 3'd7, 8'h00);
    peek("wrap_r0", 3'd0, 8'h02);

    // COMPARE equal operands
    load(3'd5, 8'h2A);
    load(3'd6, 8'h2A);
    offer(4'hF, 3'd5, 3'd6, 1'b0);
    tick(1);
    chk("cmp_flags", flags, 4'h1);
    chk("cmp_no_wb", wb_valid, 1'b0);
    peek("cmp_r5", 3'd5, 8'h2A);

    // three back-to-back instructions with valid held
    tick(1);
    c0 = acc_cnt;
    offer(4'h0, 3'd1, 3'd2, 1'b1);
    offer(4'hE, 3'd3, 3'd4, 1'b1);
    offer(4'h0, 3'd5, 3'd6, 1'b1);
    ifc.instr_valid = 1'b0;
    chk("b2b_count", 16'(acc_cnt - c0), 16'd3);
    chk("b2b_gap_add", 16'(acc_cyc[acc_cyc.size()-2] - acc_cyc[acc_cyc.size()-3]), 16'd2);
    chk("b2b_gap_mul", 16'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 16'd3);
    tick(2);

    // load and instruction offered together: load first, accept next edge, rd == rs
    ifc.instr_op = 4'h0;
    ifc.instr_rd = 3'd1;
    ifc.instr_rs = 3'd1;
    ifc.instr_valid = 1'b1;
    ld_en = 1'b1;
    ld_addr = 3'd1;
    ld_data = 8'h11;
    tick(1);
    ld_en = 1'b0;
    c0 = acc_cnt;
    offer(4'h0, 3'd1, 3'd1, 1'b0);
    chk("ld_then_accept", 16'(acc_cyc[acc_cyc.size()-1] - ld_cyc), 16'd1);
    tick(1);
    peek("ldsame_r1", 3'd1, 8'h22);

    // reset during the high-byte writeback of a MULTIPLY
    load(3'd3, 8'h10);
    load(3'd4, 8'h20);
    offer(4'hE, 3'd3, 3'd4, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_flags", flags, 4'h0);
    chk("midrst_wb", wb_valid, 1'b0);
    for (int i = 0; i < 8; i++) peek("midrst_reg", 3'(i), 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    peek("postrst_r4", 3'd4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
